// File: rtl/dcache_controller_if.sv
// Bus interfaces for the data cache: CPU memory-stage side and main-memory side.
// Handshake: mem_req/mem_we/mem_addr/mem_wdata are held stable by the master until a cycle with mem_ready=1; that cycle completes one beat (write accepted or mem_rdata valid).

interface dcache_cpu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_read;
  logic                  cpu_write;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  stall;

  modport master (
    output cpu_addr, cpu_wdata, cpu_read, cpu_write,
    input  cpu_rdata, stall
  );
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_read, cpu_write,
    output cpu_rdata, stall
  );
endinterface

interface dcache_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Loads hit with zero wait; misses refill a whole line word by word; stores always go to memory.

module dcache_controller #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_LINES   = 64,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  dcache_cpu_if.slave cpu,
  dcache_mem_if.master mem,
  output logic [1:0]  dbg_state
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2,
    S_WDONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [OFF_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;

  // Line storage has no reset; only the valid bits decide whether contents count.
  logic [DATA_WIDTH-1:0]  data_q [NUM_LINES][BLOCK_WORDS];
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];

  logic [OFF_W-1:0]       req_off;
  logic [IDX_W-1:0]       req_idx;
  logic [TAG_W-1:0]       req_tag;
  logic                   hit;
  logic                   stall;
  logic [DATA_WIDTH-1:0]  rdata;
  logic                   data_we;
  logic [OFF_W-1:0]       data_woff;
  logic [DATA_WIDTH-1:0]  data_wdata;
  logic                   tag_we;
  logic                   unused_addr_lsb;

  assign req_off = cpu.cpu_addr[2 +: OFF_W];
  assign req_idx = cpu.cpu_addr[2 + OFF_W +: IDX_W];
  assign req_tag = cpu.cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign cnt_inc = cnt_q + OFF_W'(1);
  assign unused_addr_lsb = ^cpu.cpu_addr[1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    data_we     = 1'b0;
    data_woff   = req_off;
    data_wdata  = cpu.cpu_wdata;
    tag_we      = 1'b0;
    stall       = 1'b0;
    rdata       = '0;

    case (state_q)
      S_IDLE: begin
        if (cpu.cpu_read && hit) rdata = data_q[req_idx][req_off];
        // Stores win over loads; a store hit updates the line, a miss leaves it alone.
        if (cpu.cpu_write) begin
          stall       = 1'b1;
          data_we     = hit;
          state_d     = S_WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {cpu.cpu_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata_d = cpu.cpu_wdata;
        end else if (cpu.cpu_read && !hit) begin
          stall      = 1'b1;
          state_d    = S_REFILL;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
        end
      end
      S_REFILL: begin
        stall = 1'b1;
        if (mem.mem_ready) begin
          data_we    = 1'b1;
          data_woff  = cnt_q;
          data_wdata = mem.mem_rdata;
          cnt_d      = cnt_inc;
          mem_addr_d = {req_tag, req_idx, cnt_inc, 2'b00};
          if (cnt_q == LAST_BEAT) begin
            valid_d[req_idx] = 1'b1;
            tag_we           = 1'b1;
            state_d          = S_IDLE;
            mem_req_d        = 1'b0;
          end
        end
      end
      S_WRITE: begin
        stall = 1'b1;
        if (mem.mem_ready) begin
          state_d   = S_WDONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      S_WDONE: begin
        // Lets the pipeline step past the store before any new request is looked at.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we && rst) data_q[req_idx][data_woff] <= data_wdata;
    if (tag_we && rst)  tag_q[req_idx] <= req_tag;
  end

  assign cpu.stall     = stall;
  assign cpu.cpu_rdata = rdata;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a bench-side memory answers each request after a
// chosen number of wait cycles; expected addresses, data and stall lengths are hand-derived.

module tb_dcache_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  dcache_cpu_if cpu_bus ();
  dcache_mem_if mem_bus ();

  dcache_controller dut (
    .clk       (clk),
    .rst       (rst),
    .cpu       (cpu_bus),
    .mem       (mem_bus),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  // Load: serve refill beats as base+beat after wait_n idle cycles each, then check result.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [31:0] base,
                         input int wait_n, input int exp_cyc, input int exp_beats,
                         input logic [31:0] exp_data);
    int          cyc;
    int          beat;
    int          wcnt;
    logic [31:0] line;
    cyc  = 0;
    beat = 0;
    wcnt = 0;
    line = addr & 32'hFFFF_FFF0;
    cpu_bus.cpu_addr  = addr;
    cpu_bus.cpu_read  = 1'b1;
    cpu_bus.cpu_write = 1'b0;
    #1;
    while (cpu_bus.stall === 1'b1 && cyc < 200) begin
      if (mem_bus.mem_req === 1'b1) begin
        check({tag, "_mem_addr"}, mem_bus.mem_addr, line + 32'(beat * 4));
        check({tag, "_mem_we"}, {31'b0, mem_bus.mem_we}, 32'd0);
        if (wcnt == wait_n) begin
          mem_bus.mem_ready = 1'b1;
          mem_bus.mem_rdata = base + 32'(beat);
          beat++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      @(posedge clk);
      #1;
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = '0;
      cyc++;
    end
    check({tag, "_stall_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_beats"}, 32'(beat), 32'(exp_beats));
    check({tag, "_rdata"}, cpu_bus.cpu_rdata, exp_data);
    check({tag, "_mem_req_idle"}, {31'b0, mem_bus.mem_req}, 32'd0);
    cpu_bus.cpu_read = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Store: accept the write after wait_n cycles; also_read raises cpu_read alongside.
  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input int wait_n, input int exp_cyc, input logic also_read);
    int cyc;
    int wcnt;
    cyc  = 0;
    wcnt = 0;
    cpu_bus.cpu_addr  = addr;
    cpu_bus.cpu_wdata = data;
    cpu_bus.cpu_write = 1'b1;
    cpu_bus.cpu_read  = also_read;
    #1;
    check({tag, "_stall_first"}, {31'b0, cpu_bus.stall}, 32'd1);
    while (cpu_bus.stall === 1'b1 && cyc < 200) begin
      if (mem_bus.mem_req === 1'b1) begin
        check({tag, "_mem_we"}, {31'b0, mem_bus.mem_we}, 32'd1);
        check({tag, "_mem_addr"}, mem_bus.mem_addr, addr & 32'hFFFF_FFFC);
        check({tag, "_mem_wdata"}, mem_bus.mem_wdata, data);
        if (wcnt == wait_n) mem_bus.mem_ready = 1'b1;
        else wcnt++;
      end
      @(posedge clk);
      #1;
      mem_bus.mem_ready = 1'b0;
      cyc++;
    end
    check({tag, "_stall_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_wdone_state"}, 32'(dbg_state), 32'd3);
    check({tag, "_wdone_req"}, {30'b0, mem_bus.mem_req, mem_bus.mem_we}, 32'd0);
    // Request still held through WDONE: it must be ignored, landing in IDLE with no new write.
    @(posedge clk);
    #1;
    check({tag, "_after_wdone_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_after_wdone_req"}, {31'b0, mem_bus.mem_req}, 32'd0);
    cpu_bus.cpu_write = 1'b0;
    cpu_bus.cpu_read  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_bus.cpu_addr  = '0;
    cpu_bus.cpu_wdata = '0;
    cpu_bus.cpu_read  = 1'b0;
    cpu_bus.cpu_write = 1'b0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = '0;

    // Reset values
    #2;
    check("rst_stall", {31'b0, cpu_bus.stall}, 32'd0);
    check("rst_rdata", cpu_bus.cpu_rdata, 32'd0);
    check("rst_mem_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_bus.mem_we}, 32'd0);
    check("rst_mem_addr", mem_bus.mem_addr, 32'd0);
    check("rst_mem_wdata", mem_bus.mem_wdata, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    #20;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Cold load: 1 miss cycle + 4 beats x (2 wait + 1 ready) = 13 stall cycles
    do_load("cold_100", 32'h100, 32'hA0, 2, 13, 4, 32'hA0);
    do_load("hit_108", 32'h108, 32'h0, 0, 0, 0, 32'hA2);

    // Store hit: 1 IDLE cycle + 3 wait + 1 ready = 5
    do_store("st_hit_104", 32'h104, 32'hDEAD_BEEF, 3, 5, 1'b0);
    do_load("hit_104", 32'h104, 32'h0, 0, 0, 0, 32'hDEAD_BEEF);

    // Store miss does not allocate: the following load refills
    do_store("st_miss_2000", 32'h2000, 32'h1234_5678, 1, 3, 1'b0);
    do_load("miss_2000", 32'h2000, 32'h70, 0, 5, 4, 32'h70);

    // Read and write together: write wins, then the line holds the new word
    do_store("st_both_108", 32'h108, 32'h5555_AAAA, 0, 2, 1'b1);
    do_load("hit_108_new", 32'h108, 32'h0, 0, 0, 0, 32'h5555_AAAA);

    // Conflict eviction on index 0x10
    do_load("hit_100", 32'h100, 32'h0, 0, 0, 0, 32'hA0);
    do_load("evict_500", 32'h500, 32'h50, 1, 9, 4, 32'h50);
    do_load("reload_100", 32'h100, 32'hA0, 0, 5, 4, 32'hA0);
    do_load("hit_10c", 32'h10C, 32'h0, 0, 0, 0, 32'hA3);

    // Reset during the second refill beat
    cpu_bus.cpu_addr = 32'h300;
    cpu_bus.cpu_read = 1'b1;
    #1;
    check("mid_miss_stall", {31'b0, cpu_bus.stall}, 32'd1);
    @(posedge clk);
    #1;
    check("mid_beat0_addr", mem_bus.mem_addr, 32'h300);
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 32'h30;
    @(posedge clk);
    #1;
    mem_bus.mem_ready = 1'b0;
    check("mid_beat1_addr", mem_bus.mem_addr, 32'h304);
    check("mid_beat1_req", {31'b0, mem_bus.mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_req", {31'b0, mem_bus.mem_req}, 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check("mid_rst_addr", mem_bus.mem_addr, 32'd0);
    cpu_bus.cpu_read = 1'b0;
    #2;
    rst = 1'b1;
    do_load("rst_reload_300", 32'h300, 32'h40, 0, 5, 4, 32'h40);
    // Valid bits were cleared, so a previously cached line misses again
    do_load("rst_miss_100", 32'h100, 32'hC0, 0, 5, 4, 32'hC0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
